conv_tile_mem_ctrl: RTL and testbench
=====================================

// Module: conv_tile_mem_ctrl
// PURPOSE
//  Runtime-configurable address/control sequencer for the weight-stationary MAC array.
//  It sits between the weight, ifmap and ofmap SinglePortRams and the MAC array.
//  It supersedes the fixed-geometry controller: conv geometry is a runtime input latched
//  at start, it adds stride and zero padding, and ofmap writeback stalls on ofmap_ready_in.
// PARAMETERS
//  MAC_ROW         16  array rows; weight rows per block prefetch
//  MAC_COL         16  array cols; ofmap channels per tile
//  W_ADDR_BIT      11  weight RAM address width
//  IFMAP_ADDR_BIT  9   ifmap RAM address width
//  OFMAP_ADDR_BIT  10  ofmap RAM address width
//  DIM_BIT         6   width of spatial-dimension config fields
// PORTS
//  clk                   in   1               clock
//  rst                   in   1               async reset, active-high
//  start_in              in   1               start pulse; sampled only in IDLE
//  cfg_oc_tiles_in       in   4               ofmap channels / MAC_COL (OCT)
//  cfg_ic_groups_in      in   4               ifmap channels / MAC_ROW (ICG)
//  cfg_k_in              in   3               square kernel size K (1..7)
//  cfg_stride_in         in   2               stride S (1..3)
//  cfg_pad_in            in   2               zero pad P on every edge (0..3)
//  cfg_in_dim_in         in   DIM_BIT         square ifmap dim ID
//  cfg_out_dim_in        in   DIM_BIT         square ofmap dim OD
//  ofmap_ready_in        in   1               ofmap sink ready for one row
//  w_prefetch_out        out  1               high for every prefetch slot
//  w_addr_out            out  W_ADDR_BIT      weight RAM address
//  w_read_en_out         out  1               weight read strobe
//  ifmap_start_out       out  1               high on first stream slot of each block
//  ifmap_addr_out        out  IFMAP_ADDR_BIT  ifmap RAM address
//  ifmap_read_en_out     out  1               ifmap read strobe; in-bounds slots only
//  ifmap_pad_out         out  1               padded slot; datapath injects zero row
//  mac_done_out          out  1               1-cycle pulse: all MAC traffic issued
//  ofmap_addr_out        out  OFMAP_ADDR_BIT  ofmap RAM address
//  ofmap_write_en_out    out  1               ofmap write strobe
//  ofmap_write_done_out  out  1               1-cycle pulse after the last ofmap write
// BEHAVIOUR
//  - All outputs are registered. rst asserted: every output is 0 immediately, the FSM
//    goes to IDLE, and all counters clear. Reset mid-run abandons the run with no done pulses.
//  - FSM: IDLE -> PREFETCH -> STREAM -> (PREFETCH | WRITE) -> IDLE.
//    The edge with start_in=1 in IDLE latches all cfg_*. start_in is ignored outside IDLE.
//  - Loop order: tile t<OCT { icg<ICG { ky<K { kx<K { block } } } }. NB=ICG*K*K.
//  - PREFETCH: MAC_ROW consecutive cycles, w_read_en_out=w_prefetch_out=1,
//    w_addr_out=(t*NB+b)*MAC_ROW+r. The address is contiguous across blocks and tiles.
//  - STREAM: OD*OD consecutive slots, ox fastest, one per cycle, no bubbles.
//    Per slot: iy=oy*S+ky-P, ix=ox*S+kx-P, computed signed.
//    In-bounds slot (0<=iy,ix<ID): read_en=1, addr=(icg*ID+iy)*ID+ix, truncated to IFMAP_ADDR_BIT.
//    Out-of-bounds slot: read_en=0, pad=1, addr holds its previous value.
//  - Blocks run back to back. The first prefetch slot appears in the cycle after start is latched.
//  - After the last stream slot of the last block: enter WRITE and pulse mac_done_out once.
//  - WRITE: OCT*OD*OD rows. Each edge with ofmap_ready_in=1 and rows remaining issues
//    write_en=1 next cycle, addr=row index from 0. ready low gives write_en=0 and holds addr.
//    Ready held low stalls indefinitely.
//  - The cycle after the final write: ofmap_write_done_out=1 for one cycle, then IDLE.
//  - OCT, ICG, K or OD =0: no reads. mac_done pulses on the cycle after start;
//    write_done pulses on the following cycle.
// TESTING
//  - Config OCT=4, ICG=2, K=3, S=1, P=0, ID=16, OD=14, ready held 1 -> 1152 weight reads
//    (addr 0..1151), 14112 ifmap reads, 0 pad slots, 784 writes at addr 0..783, one mac_done, one write_done.
//  - OCT=1, ICG=1, K=3, S=1, P=1, ID=OD=4 -> 9 blocks x 16 slots; 100 reads, 44 pad slots;
//    block (0,0) first slot pad=1; 6th slot read at addr 0.
//  - S=2, K=3, P=0, ID=9, OD=4 -> block 0: slot 1 addr 2, slot 4 addr 18; last block slot 15 addr 80.
//  - Writeback with ofmap_ready_in toggling 1,0,0,1 repeating -> writes only after ready-high
//    edges, addresses gap-free, write_done exactly once after row OCT*OD*OD-1.
//  - rst pulsed mid-STREAM, then start -> outputs 0 during reset, no done pulses;
//    restart gives w_addr_out=0 on the first prefetch.
//  - start_in pulsed during STREAM and WRITE -> ignored; read/write totals unchanged.

Source files
------------

// File: rtl/conv_tile_mem_ctrl.sv
// Address/control sequencer for the weight-stationary MAC array: weight prefetch,
// strided/padded ifmap streaming and ready-throttled ofmap writeback, geometry latched at start.
module conv_tile_mem_ctrl #(
  parameter int unsigned MAC_ROW        = 16,
  parameter int unsigned MAC_COL        = 16,
  parameter int unsigned W_ADDR_BIT     = 11,
  parameter int unsigned IFMAP_ADDR_BIT = 9,
  parameter int unsigned OFMAP_ADDR_BIT = 10,
  parameter int unsigned DIM_BIT        = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_in,
  input  logic [3:0]                cfg_oc_tiles_in,
  input  logic [3:0]                cfg_ic_groups_in,
  input  logic [2:0]                cfg_k_in,
  input  logic [1:0]                cfg_stride_in,
  input  logic [1:0]                cfg_pad_in,
  input  logic [DIM_BIT-1:0]        cfg_in_dim_in,
  input  logic [DIM_BIT-1:0]        cfg_out_dim_in,
  input  logic                      ofmap_ready_in,
  output logic                      w_prefetch_out,
  output logic [W_ADDR_BIT-1:0]     w_addr_out,
  output logic                      w_read_en_out,
  output logic                      ifmap_start_out,
  output logic [IFMAP_ADDR_BIT-1:0] ifmap_addr_out,
  output logic                      ifmap_read_en_out,
  output logic                      ifmap_pad_out,
  output logic                      mac_done_out,
  output logic [OFMAP_ADDR_BIT-1:0] ofmap_addr_out,
  output logic                      ofmap_write_en_out,
  output logic                      ofmap_write_done_out
);

  localparam int unsigned RW      = $clog2(MAC_ROW);
  localparam int unsigned ROW_BIT = 4 + 2 * DIM_BIT;

  if (MAC_ROW < 2 || MAC_COL < 1) begin : g_param_check
    $error("conv_tile_mem_ctrl: MAC_ROW must be >= 2 and MAC_COL >= 1");
  end

  // IDLE wait start | PREFETCH weight rows | STREAM ifmap slots | WRITE ofmap rows
  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, WRITE} state_e;
  state_e state_q, state_d;

  logic [3:0]                oct_q, oct_d, icgn_q, icgn_d;
  logic [2:0]                k_q, k_d;
  logic [1:0]                s_q, s_d, p_q, p_d;
  logic [DIM_BIT-1:0]        id_q, id_d, od_q, od_d;
  logic [3:0]                t_q, t_d, icg_q, icg_d;
  logic [2:0]                ky_q, ky_d, kx_q, kx_d;
  logic [RW-1:0]             r_q, r_d;
  logic [DIM_BIT-1:0]        ox_q, ox_d, oy_q, oy_d;
  logic [ROW_BIT-1:0]        row_q, row_d, rows_q, rows_d;
  logic                      wpf_q, wpf_d, wre_q, wre_d, ist_q, ist_d, ire_q, ire_d;
  logic                      ipad_q, ipad_d, mdone_q, mdone_d, owe_q, owe_d, owd_q, owd_d;
  logic [W_ADDR_BIT-1:0]     waddr_q, waddr_d;
  logic [IFMAP_ADDR_BIT-1:0] iaddr_q, iaddr_d, ilin;
  logic [OFMAP_ADDR_BIT-1:0] oaddr_q, oaddr_d;
  logic                      issue_slot, in_bounds, last_slot, last_blk;
  logic                      last_kx, last_ky, last_icg, last_t, degenerate;
  logic [9:0]                sy, sx, iy, ix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      oct_q <= '0; icgn_q <= '0; k_q <= '0; s_q <= '0; p_q <= '0; id_q <= '0; od_q <= '0;
      t_q <= '0; icg_q <= '0; ky_q <= '0; kx_q <= '0; r_q <= '0; ox_q <= '0; oy_q <= '0;
      row_q <= '0; rows_q <= '0;
      wpf_q <= 1'b0; wre_q <= 1'b0; ist_q <= 1'b0; ire_q <= 1'b0; ipad_q <= 1'b0;
      mdone_q <= 1'b0; owe_q <= 1'b0; owd_q <= 1'b0;
      waddr_q <= '0; iaddr_q <= '0; oaddr_q <= '0;
    end else begin
      state_q <= state_d;
      oct_q <= oct_d; icgn_q <= icgn_d; k_q <= k_d; s_q <= s_d; p_q <= p_d; id_q <= id_d; od_q <= od_d;
      t_q <= t_d; icg_q <= icg_d; ky_q <= ky_d; kx_q <= kx_d; r_q <= r_d; ox_q <= ox_d; oy_q <= oy_d;
      row_q <= row_d; rows_q <= rows_d;
      wpf_q <= wpf_d; wre_q <= wre_d; ist_q <= ist_d; ire_q <= ire_d; ipad_q <= ipad_d;
      mdone_q <= mdone_d; owe_q <= owe_d; owd_q <= owd_d;
      waddr_q <= waddr_d; iaddr_q <= iaddr_d; oaddr_q <= oaddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    oct_d = oct_q; icgn_d = icgn_q; k_d = k_q; s_d = s_q; p_d = p_q; id_d = id_q; od_d = od_q;
    t_d = t_q; icg_d = icg_q; ky_d = ky_q; kx_d = kx_q; r_d = r_q; ox_d = ox_q; oy_d = oy_q;
    row_d = row_q; rows_d = rows_q;
    wpf_d = 1'b0; wre_d = 1'b0; ist_d = 1'b0; ire_d = 1'b0; ipad_d = 1'b0;
    mdone_d = 1'b0; owe_d = 1'b0; owd_d = 1'b0;
    waddr_d = waddr_q; iaddr_d = iaddr_q; oaddr_d = oaddr_q;
    issue_slot = 1'b0;

    last_kx   = (kx_q == k_q - 3'd1);
    last_ky   = (ky_q == k_q - 3'd1);
    last_icg  = (icg_q == icgn_q - 4'd1);
    last_t    = (t_q == oct_q - 4'd1);
    last_blk  = last_kx && last_ky && last_icg && last_t;
    last_slot = (ox_q == od_q - DIM_BIT'(1)) && (oy_q == od_q - DIM_BIT'(1));
    degenerate = (cfg_oc_tiles_in == 4'd0) || (cfg_ic_groups_in == 4'd0) ||
                 (cfg_k_in == 3'd0) || (cfg_out_dim_in == '0);

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          oct_d = cfg_oc_tiles_in; icgn_d = cfg_ic_groups_in; k_d = cfg_k_in;
          s_d = cfg_stride_in; p_d = cfg_pad_in; id_d = cfg_in_dim_in; od_d = cfg_out_dim_in;
          t_d = '0; icg_d = '0; ky_d = '0; kx_d = '0; r_d = '0; ox_d = '0; oy_d = '0; row_d = '0;
          if (degenerate) begin
            rows_d  = '0;
            state_d = WRITE;
            mdone_d = 1'b1;
          end else begin
            rows_d  = ROW_BIT'(cfg_oc_tiles_in) * ROW_BIT'(cfg_out_dim_in) * ROW_BIT'(cfg_out_dim_in);
            state_d = PREFETCH;
            wpf_d   = 1'b1;
            wre_d   = 1'b1;
            waddr_d = '0;
          end
        end
      end
      PREFETCH: begin
        if (r_q == RW'(MAC_ROW - 1)) begin
          state_d    = STREAM;
          ox_d       = '0;
          oy_d       = '0;
          ist_d      = 1'b1;
          issue_slot = 1'b1;
        end else begin
          r_d     = r_q + RW'(1);
          wpf_d   = 1'b1;
          wre_d   = 1'b1;
          waddr_d = waddr_q + W_ADDR_BIT'(1);
        end
      end
      STREAM: begin
        if (last_slot) begin
          if (last_blk) begin
            state_d = WRITE;
            mdone_d = 1'b1;
            row_d   = '0;
          end else begin
            if (!last_kx) kx_d = kx_q + 3'd1;
            else begin
              kx_d = '0;
              if (!last_ky) ky_d = ky_q + 3'd1;
              else begin
                ky_d = '0;
                if (!last_icg) icg_d = icg_q + 4'd1;
                else begin
                  icg_d = '0;
                  t_d   = t_q + 4'd1;
                end
              end
            end
            state_d = PREFETCH;
            r_d     = '0;
            wpf_d   = 1'b1;
            wre_d   = 1'b1;
            waddr_d = waddr_q + W_ADDR_BIT'(1);
          end
        end else begin
          if (ox_q == od_q - DIM_BIT'(1)) begin
            ox_d = '0;
            oy_d = oy_q + DIM_BIT'(1);
          end else begin
            ox_d = ox_q + DIM_BIT'(1);
          end
          issue_slot = 1'b1;
        end
      end
      WRITE: begin
        if (row_q == rows_q) begin
          owd_d   = 1'b1;
          state_d = IDLE;
        end else if (ofmap_ready_in) begin
          owe_d   = 1'b1;
          oaddr_d = row_q[OFMAP_ADDR_BIT-1:0];
          row_d   = row_q + ROW_BIT'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Padding test done unsigned: the slot is in bounds iff P <= oy*S+ky < ID+P.
    sy = 10'(oy_d) * 10'(s_q) + 10'(ky_q);
    sx = 10'(ox_d) * 10'(s_q) + 10'(kx_q);
    iy = sy - 10'(p_q);
    ix = sx - 10'(p_q);
    in_bounds = (sy >= 10'(p_q)) && (iy < 10'(id_q)) && (sx >= 10'(p_q)) && (ix < 10'(id_q));
    ilin = IFMAP_ADDR_BIT'((18'(icg_q) * 18'(id_q) + 18'(iy)) * 18'(id_q) + 18'(ix));
    if (issue_slot) begin
      if (in_bounds) begin
        ire_d   = 1'b1;
        iaddr_d = ilin;
      end else begin
        ipad_d = 1'b1;
      end
    end
  end

  assign w_prefetch_out       = wpf_q;
  assign w_addr_out           = waddr_q;
  assign w_read_en_out        = wre_q;
  assign ifmap_start_out      = ist_q;
  assign ifmap_addr_out       = iaddr_q;
  assign ifmap_read_en_out    = ire_q;
  assign ifmap_pad_out        = ipad_q;
  assign mac_done_out         = mdone_q;
  assign ofmap_addr_out       = oaddr_q;
  assign ofmap_write_en_out   = owe_q;
  assign ofmap_write_done_out = owd_q;

endmodule

// File: tb/tb_conv_tile_mem_ctrl.sv
// Directed, table-driven bench for conv_tile_mem_ctrl: whole-run totals per geometry
// plus hand-checked slot addresses, mid-run reset and stray start pulses.
module tb_conv_tile_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic [3:0]  cfg_oc_tiles, cfg_ic_groups;
  logic [2:0]  cfg_k;
  logic [1:0]  cfg_stride, cfg_pad;
  logic [5:0]  cfg_in_dim, cfg_out_dim;
  logic        ofmap_ready;
  logic        w_prefetch, w_read_en, ifmap_start, ifmap_read_en, ifmap_pad;
  logic        mac_done, ofmap_write_en, ofmap_write_done;
  logic [10:0] w_addr;
  logic [8:0]  ifmap_addr;
  logic [9:0]  ofmap_addr;
  logic [37:0] all_outs;

  conv_tile_mem_ctrl dut (
    .clk(clk), .rst(rst), .start_in(start_in),
    .cfg_oc_tiles_in(cfg_oc_tiles), .cfg_ic_groups_in(cfg_ic_groups), .cfg_k_in(cfg_k),
    .cfg_stride_in(cfg_stride), .cfg_pad_in(cfg_pad),
    .cfg_in_dim_in(cfg_in_dim), .cfg_out_dim_in(cfg_out_dim),
    .ofmap_ready_in(ofmap_ready),
    .w_prefetch_out(w_prefetch), .w_addr_out(w_addr), .w_read_en_out(w_read_en),
    .ifmap_start_out(ifmap_start), .ifmap_addr_out(ifmap_addr),
    .ifmap_read_en_out(ifmap_read_en), .ifmap_pad_out(ifmap_pad),
    .mac_done_out(mac_done), .ofmap_addr_out(ofmap_addr),
    .ofmap_write_en_out(ofmap_write_en), .ofmap_write_done_out(ofmap_write_done)
  );

  assign all_outs = {w_prefetch, w_addr, w_read_en, ifmap_start, ifmap_addr, ifmap_read_en,
                     ifmap_pad, mac_done, ofmap_addr, ofmap_write_en, ofmap_write_done};

  always #5 clk = ~clk;

  typedef struct {
    int oct, icg, k, s, p, id, od, rmode, stray;
    int e_w, e_rd, e_pad, e_wr, e_blk, e_mac_cyc, e_wd_cyc;
  } vec_t;

  vec_t vecs[10];
  int n_checks = 0;
  int n_errors = 0;

  int n_w, n_rd, n_pad, n_wr, n_blk, n_mac, n_wd, mac_cyc, wd_cyc, seq_err, first_w, timed_out;
  int b0_re[256], b0_pad[256], b0_addr[256], lb_re[256], lb_addr[256];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic ready_pat(input int i);
    return (i % 4 == 0) || (i % 4 == 3);
  endfunction

  task automatic run_op(input vec_t v);
    int cyc, slot, last_wr, stop_at;
    n_w = 0; n_rd = 0; n_pad = 0; n_wr = 0; n_blk = 0; n_mac = 0; n_wd = 0;
    mac_cyc = 0; wd_cyc = 0; seq_err = 0; first_w = -1; timed_out = 0;
    slot = 0; last_wr = 0; stop_at = -1;
    @(negedge clk);
    cfg_oc_tiles = 4'(v.oct); cfg_ic_groups = 4'(v.icg); cfg_k = 3'(v.k);
    cfg_stride = 2'(v.s); cfg_pad = 2'(v.p); cfg_in_dim = 6'(v.id); cfg_out_dim = 6'(v.od);
    ofmap_ready = (v.rmode == 0) ? 1'b1 : ready_pat(0);
    start_in = 1'b1;
    cyc = 0;
    while (cyc != stop_at && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (w_read_en) begin
        if (!w_prefetch || w_addr != 11'(n_w)) seq_err++;
        if (n_w == 0) first_w = int'(w_addr);
        n_w++;
      end
      if (ifmap_start) begin
        n_blk++;
        slot = 0;
      end
      if (ifmap_read_en || ifmap_pad) begin
        if (ifmap_read_en && ifmap_pad) seq_err++;
        if (slot < 256) begin
          if (n_blk == 1) begin
            b0_re[slot] = int'(ifmap_read_en); b0_pad[slot] = int'(ifmap_pad);
            b0_addr[slot] = int'(ifmap_addr);
          end
          lb_re[slot] = int'(ifmap_read_en); lb_addr[slot] = int'(ifmap_addr);
        end
        slot++;
      end
      if (ifmap_read_en) n_rd++;
      if (ifmap_pad) n_pad++;
      if (ofmap_write_en) begin
        if (!ofmap_ready || ofmap_addr != 10'(n_wr)) seq_err++;
        n_wr++;
        last_wr = cyc;
      end
      if (mac_done) begin
        if (n_mac == 0) mac_cyc = cyc;
        n_mac++;
      end
      if (ofmap_write_done) begin
        if (n_mac == 0 || (n_wr > 0 && cyc != last_wr + 1)) seq_err++;
        if (n_wd == 0) begin
          wd_cyc = cyc;
          stop_at = cyc + 3;
        end
        n_wd++;
      end
      ofmap_ready = (v.rmode == 0) ? 1'b1 : ready_pat(cyc);
      start_in = (v.stray != 0) && (cyc == 120 || cyc == 295);
    end
    start_in = 1'b0;
    if (n_wd == 0) timed_out = 1;
  endtask

  task automatic check_run(input int i, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", i);
    check({tag, " timeout"}, timed_out, 0);
    check({tag, " w_reads"}, n_w, v.e_w);
    check({tag, " if_reads"}, n_rd, v.e_rd);
    check({tag, " pads"}, n_pad, v.e_pad);
    check({tag, " writes"}, n_wr, v.e_wr);
    check({tag, " blocks"}, n_blk, v.e_blk);
    check({tag, " mac_done_cnt"}, n_mac, 1);
    check({tag, " wr_done_cnt"}, n_wd, 1);
    check({tag, " sequence"}, seq_err, 0);
    if (v.e_mac_cyc != 0) check({tag, " mac_done_cyc"}, mac_cyc, v.e_mac_cyc);
    if (v.e_wd_cyc != 0) check({tag, " wr_done_cyc"}, wd_cyc, v.e_wd_cyc);
    if (v.e_w > 0) check({tag, " first_w_addr"}, first_w, 0);
  endtask

  initial begin
    int bad;
    //          oct icg k s p id od rm st   w     rd    pad wr   blk mac    wd
    vecs[0] = '{4, 2, 3, 1, 0, 16, 14, 0, 0, 1152, 14112, 0, 784, 72, 15265, 0};
    vecs[1] = '{1, 1, 3, 1, 1, 4, 4, 0, 0, 144, 100, 44, 16, 9, 289, 0};
    vecs[2] = '{1, 1, 3, 2, 0, 9, 4, 0, 0, 144, 144, 0, 16, 9, 289, 0};
    vecs[3] = '{2, 1, 1, 3, 3, 4, 3, 0, 0, 32, 8, 10, 18, 2, 51, 0};
    vecs[4] = '{1, 1, 3, 1, 1, 4, 4, 1, 0, 144, 100, 44, 16, 9, 289, 0};
    vecs[5] = '{1, 1, 3, 1, 1, 4, 4, 0, 1, 144, 100, 44, 16, 9, 289, 0};
    vecs[6] = '{0, 1, 3, 1, 1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 1, 2};
    vecs[7] = '{1, 1, 0, 1, 0, 4, 4, 0, 0, 0, 0, 0, 0, 0, 1, 2};
    vecs[8] = '{1, 1, 3, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2};
    vecs[9] = '{2, 0, 3, 1, 0, 4, 4, 0, 0, 0, 0, 0, 0, 0, 1, 2};

    rst = 1'b1; start_in = 1'b0; ofmap_ready = 1'b1;
    cfg_oc_tiles = '0; cfg_ic_groups = '0; cfg_k = '0; cfg_stride = '0; cfg_pad = '0;
    cfg_in_dim = '0; cfg_out_dim = '0;
    #1;
    check("reset_outputs", int'(all_outs != '0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", int'(all_outs != '0), 0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i]);
      check_run(i, vecs[i]);
      if (i == 1) begin
        check("pad blk0 slot0", b0_pad[0], 1);
        check("pad blk0 slot5 re", b0_re[5], 1);
        check("pad blk0 slot5 addr", b0_addr[5], 0);
      end
      if (i == 2) begin
        check("s2 blk0 slot1 addr", b0_addr[1], 2);
        check("s2 blk0 slot4 addr", b0_addr[4], 18);
        check("s2 last slot15 re", lb_re[15], 1);
        check("s2 last slot15 addr", lb_addr[15], 80);
      end
    end

    @(negedge clk);
    cfg_oc_tiles = 4'd4; cfg_ic_groups = 4'd2; cfg_k = 3'd3; cfg_stride = 2'd1; cfg_pad = 2'd0;
    cfg_in_dim = 6'd16; cfg_out_dim = 6'd14;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_in_stream", int'(ifmap_read_en), 1);
    rst = 1'b1;
    #1;
    check("rst_async_outputs", int'(all_outs != '0), 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (all_outs != '0) bad++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (all_outs != '0) bad++;
    end
    check("rst_quiet", bad, 0);
    run_op(vecs[1]);
    check_run(100, vecs[1]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
